// File: rtl/fp_sqrt_sequencer.sv
// fp_sqrt_sequencer
// State sequencer for the floating-point square-root controller. It produces
// the state code S0..S(4*ITER+2) that the output decoder turns into the
// datapath control word, and handles start/done, stalls, the special-operand
// bypass and the fixed Newton iteration count.
//
// Optional feature: define SQRT_EARLY_EXIT_EN to let the convergence flag
// conv_i end the iteration loop early, from the phase-3 state of any
// iteration except the last one. With the macro undefined, conv_i is ignored
// and every operation runs all ITER iterations.

module fp_sqrt_sequencer #(
    parameter int ITER    = 11,
    parameter int STATE_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               hold_i,
    input  logic               special_i,
    input  logic               conv_i,
    output logic [STATE_W-1:0] CurrentState_o,
    output logic [3:0]         iter_o,
    output logic [1:0]         phase_o,
    output logic               busy_o,
    output logic               done_o
);

    // Named state codes. Iteration states lie between ST_FIRST and ST_LAST.
    // Each iteration has four phases, except the last one, which has three.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = STATE_W'(0),
        ST_LOAD  = STATE_W'(1),
        ST_INIT  = STATE_W'(2),
        ST_FIRST = STATE_W'(3),
        ST_LAST  = STATE_W'(4 * ITER + 1),
        ST_OUT   = STATE_W'(4 * ITER + 2)
    } state_e;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_nextState;
    logic [STATE_W-1:0] w_offset;
    logic               w_inIter;
    logic               w_earlyExit;

    // Position of the current state within the iteration block. It is only
    // meaningful while w_inIter is high.
    assign w_offset = r_state - STATE_W'(ST_FIRST);
    assign w_inIter = (r_state >= ST_FIRST) && (r_state <= ST_LAST);

`ifdef SQRT_EARLY_EXIT_EN
    // Convergence exit is allowed only from a phase-3 state. The last
    // iteration has no phase 3, so the exit applies to iterations
    // 1..ITER-1.
    assign w_earlyExit = conv_i && w_inIter && (r_state < ST_LAST)
                         && (w_offset[1:0] == 2'd3);
`else
    logic w_unusedConv;
    assign w_unusedConv = conv_i;
    assign w_earlyExit  = 1'b0;
`endif

    // State register: synchronous active-low reset returns to idle from any state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Idle ignores hold, hold freezes every other state,
    // and codes beyond ST_OUT fall back to idle.
    always_comb begin
        w_nextState = r_state;
        if (r_state == ST_IDLE) begin
            w_nextState = start_i ? ST_LOAD : ST_IDLE;
        end else if (hold_i) begin
            w_nextState = r_state;
        end else if (r_state == ST_LOAD) begin
            w_nextState = special_i ? ST_OUT : ST_INIT;
        end else if (r_state == ST_INIT) begin
            w_nextState = ST_FIRST;
        end else if (w_earlyExit) begin
            w_nextState = ST_OUT;
        end else if (w_inIter && (r_state < ST_LAST)) begin
            w_nextState = r_state + STATE_W'(1);
        end else if (r_state == ST_LAST) begin
            w_nextState = ST_OUT;
        end else begin
            w_nextState = ST_IDLE;
        end
    end

    // Output decode. Everything derives from the state register, so the
    // decoder sees a stable code for the whole cycle.
    always_comb begin
        CurrentState_o = r_state;
        iter_o         = 4'd0;
        phase_o        = 2'd0;
        busy_o         = (r_state != ST_IDLE);
        done_o         = (r_state == ST_OUT);
        if (w_inIter) begin
            iter_o  = 4'(w_offset >> 2) + 4'd1;
            phase_o = w_offset[1:0];
        end
    end

endmodule

// File: tb/tb_fp_sqrt_sequencer.sv
// tb_fp_sqrt_sequencer
// Scoreboard bench: the driver applies one cycle of inputs, advances a
// behavioural model of the operation and queues the outputs expected after the
// clock edge. A monitor pops one entry after every edge and compares it with
// the outputs. The model tracks the operation as a phase (idle, load, init,
// iterate, output) plus an iteration/phase pair. It does not use the state
// codes directly.

module tb_fp_sqrt_sequencer;

    localparam int ITER   = 11;
    localparam int OUTST  = 4 * ITER + 2;

    logic       clk;
    logic       rstN;
    logic       start;
    logic       hold;
    logic       special;
    logic       conv;
    logic [5:0] curState;
    logic [3:0] iterOut;
    logic [1:0] phaseOut;
    logic       busy;
    logic       done;

    typedef struct {
        logic [5:0] st;
        logic [3:0] it;
        logic [1:0] ph;
        logic       busy;
        logic       done;
    } expect_t;

    expect_t scoreQ[$];

    int checks     = 0;
    int failures   = 0;
    int busyCycles = 0;
    int doneCycles = 0;
    int cycleNo    = 0;

    // Model: 0 idle, 1 load, 2 init, 3 iterating, 4 output.
    int mKind = 0;
    int mIt   = 0;
    int mPh   = 0;

    fp_sqrt_sequencer #(.ITER(ITER), .STATE_W(6)) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .start_i        (start),
        .hold_i         (hold),
        .special_i      (special),
        .conv_i         (conv),
        .CurrentState_o (curState),
        .iter_o         (iterOut),
        .phase_o        (phaseOut),
        .busy_o         (busy),
        .done_o         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int modelCode();
        case (mKind)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 3 + 4 * (mIt - 1) + mPh;
            default: return OUTST;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, actual, expected, cycleNo);
        end
    endtask

    // Advance the operation model by one clock edge using the inputs of this cycle.
    task automatic modelStep(input logic r, input logic s, input logic h,
                             input logic sp, input logic c);
        if (!r) begin
            mKind = 0;
        end else begin
            case (mKind)
                0: if (s) mKind = 1;
                1: if (!h) mKind = sp ? 4 : 2;
                2: if (!h) begin mKind = 3; mIt = 1; mPh = 0; end
                3: if (!h) begin
`ifdef SQRT_EARLY_EXIT_EN
                    if (c && mPh == 3) mKind = 4;
                    else
`endif
                    if (mIt == ITER && mPh == 2) mKind = 4;
                    else if (mPh == 3) begin mIt++; mPh = 0; end
                    else mPh++;
                end
                default: if (!h) mKind = 0;
            endcase
        end
        if (c) begin end
    endtask

    // Drive one cycle of inputs, step the model, queue the expected outputs.
    task automatic applyStimulus(input logic r, input logic s, input logic h,
                                 input logic sp, input logic c);
        expect_t e;
        @(negedge clk);
        rstN    = r;
        start   = s;
        hold    = h;
        special = sp;
        conv    = c;
        modelStep(r, s, h, sp, c);
        e.st   = 6'(modelCode());
        e.it   = (mKind == 3) ? 4'(mIt) : 4'd0;
        e.ph   = (mKind == 3) ? 2'(mPh) : 2'd0;
        e.busy = (mKind != 0);
        e.done = (mKind == 4);
        scoreQ.push_back(e);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Run idle cycles until the model sits in the given state code.
    task automatic advanceTo(input int code);
        int n = 0;
        while (modelCode() != code && n < 100) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        checkOutput("advanceTo", 8'(modelCode()), 8'(code));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic clearCounts();
        settle();
        busyCycles = 0;
        doneCycles = 0;
    endtask

    // Monitor: after every edge, compare outputs with the oldest queued expectation.
    always @(posedge clk) begin
        expect_t e;
        #1;
        cycleNo++;
        if (busy === 1'b1) busyCycles++;
        if (done === 1'b1) doneCycles++;
        if (scoreQ.size() > 0) begin
            e = scoreQ.pop_front();
            checkOutput("state", 8'(curState), 8'(e.st));
            checkOutput("iter",  8'(iterOut),  8'(e.it));
            checkOutput("phase", 8'(phaseOut), 8'(e.ph));
            checkOutput("busy",  8'(busy),     8'(e.busy));
            checkOutput("done",  8'(done),     8'(e.done));
        end
    end

    initial begin
        rstN = 1'b0; start = 1'b0; hold = 1'b0; special = 1'b0; conv = 1'b0;

        // Reset for two cycles, then idle with start low.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycles(4);

        // Full run: 46 busy cycles, one done cycle.
        clearCounts();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(50);
        settle();
        checkOutput("fullRunBusy", 8'(busyCycles), 8'd46);
        checkOutput("fullRunDone", 8'(doneCycles), 8'd1);

        // Stall for three cycles in S20.
        clearCounts();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        advanceTo(20);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(40);
        settle();
        checkOutput("stallRunBusy", 8'(busyCycles), 8'd49);

        // Special-operand bypass: S1 -> S46 -> S0.
        clearCounts();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idleCycles(4);
        settle();
        checkOutput("specialBusy", 8'(busyCycles), 8'd2);
        checkOutput("specialDone", 8'(doneCycles), 8'd1);

        // Start pulses while busy are ignored, including in the output state.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        advanceTo(10);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        advanceTo(OUTST);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(3);

        // Reset in the middle of an operation.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        advanceTo(30);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycles(3);

        // Convergence flag in S13 (phase 2) and then in S14 (phase 3).
        clearCounts();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        advanceTo(13);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idleCycles(40);
        settle();
`ifdef SQRT_EARLY_EXIT_EN
        checkOutput("convRunBusy", 8'(busyCycles), 8'd15);
`else
        checkOutput("convRunBusy", 8'(busyCycles), 8'd46);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) >= 2),
                          ($urandom_range(0, 99) < 30),
                          ($urandom_range(0, 99) < 20),
                          ($urandom_range(0, 99) < 10),
                          ($urandom_range(0, 99) < 10));
        end
        idleCycles(60);
        settle();
        settle();
        checkOutput("queueDrained", 8'(scoreQ.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_sqrt_sequencer.md
# fp_sqrt_sequencer

State sequencer for the floating-point square-root controller. Generates the 6-bit `CurrentState_o` code (S0–S46) consumed by the controller output decoder, which turns each state into the 14-bit datapath control word. Handles the start/done handshake, datapath stalls, special-operand bypass, and the fixed Newton iteration count.

## Interface
- `ITER`, default 11: number of Newton iterations. The decoder is built for 11; the legal range is 1–11.
- `STATE_W`, default 6: width of the state code.
- `clk_i`  in  1: clock; all flops update on the rising edge.
- `rst_ni`  in  1: synchronous active-low reset.
- `start_i`  in  1: begin an operation; sampled only in S0.
- `hold_i`  in  1: datapath busy; freezes the sequencer.
- `special_i`  in  1: the operand is zero, infinity, NaN or negative; sampled in S1.
- `conv_i`  in  1: convergence flag from the datapath; used only when `SQRT_EARLY_EXIT_EN` is defined.
- `CurrentState_o`  out  STATE_W: current state code, fed to the output decoder.
- `iter_o`  out  4: current iteration number, 1..ITER. It is 0 outside the iteration states.
- `phase_o`  out  2: phase within the current iteration, 0..3. It is 0 outside the iteration states.
- `busy_o`  out  1: high when the state is not S0.
- `done_o`  out  1: high in the output state S(4·ITER+2), which is S46 at default.

## Operation
- A single registered state, `state`. All outputs decode combinationally from `state`.
- Let LAST = 4·ITER+1 (45) and OUT = 4·ITER+2 (46).
- Transitions, in priority order: reset, then hold, then the table below.
- S0 (idle): go to S1 if `start_i`, otherwise stay in S0.
- S1 (load): go to OUT if `special_i`, otherwise go to S2.
- S2 (init): go to S3.
- S3..LAST−1: advance to state+1.
- LAST: go to OUT.
  - The last iteration has only 3 phases (S43–S45), matching the decoder.
- OUT: go to S0 unconditionally.
- `hold_i`=1 in any state other than S0 keeps `state` unchanged.
  - `hold_i` in S0 is ignored; `start_i` is still accepted there.
- `start_i` outside S0 is ignored; nothing is queued.
  - `start_i` asserted in OUT is ignored, so back-to-back operations need one idle cycle in S0.
- `special_i` matters only in S1 when not held. Elsewhere it is ignored.
- Iteration decode for S3..LAST: `iter_o` = ((state−3)>>2)+1 and `phase_o` = (state−3)&3.
- Illegal codes (47–63) go to S0 on the next edge. While in an illegal code, `busy_o`=1 and `done_o`=0.

## Timing
- Reset: `rst_ni`=0 at a rising edge forces `state`=S0 on that edge, even mid-operation.
- Output values in S0: `CurrentState_o`=0, `iter_o`=0, `phase_o`=0, `busy_o`=0, `done_o`=0.
- A start sampled at edge E puts the sequencer in S1 in the cycle after E.
- Normal run, no holds, no bypass:
  - S1..OUT is 46 cycles.
  - `done_o` is high for exactly 1 cycle (S46).
  - S0 follows.
- Special bypass: S1 → S46 → S0. `done_o` rises 2 cycles after S1 is entered.
- Each cycle with `hold_i`=1 adds exactly one cycle of latency. A hold in OUT extends `done_o`.
- The output decoder is combinational, so the control word for state N is valid during the same cycle that `CurrentState_o`=N.

## Configuration
- `SQRT_EARLY_EXIT_EN` defined:
  - In the phase-3 state of iterations 1..ITER−1 (S6, S10, …, S42), `conv_i`=1 with no hold sends the sequencer to OUT instead of state+1.
  - Hold has priority over this exit.
- `SQRT_EARLY_EXIT_EN` undefined:
  - `conv_i` is unused and its port remains.
  - The sequencer always runs the full ITER iterations.

## Test plan
- Reset and idle: hold `rst_ni`=0 for 2 cycles, then release.
  - Required: all outputs 0 and `state` stays S0 while `start_i`=0.
- Full run: pulse `start_i` for 1 cycle.
  - `CurrentState_o` steps 1,2,…,46,0.
  - `done_o` is high for exactly 1 cycle, 46 cycles after S1 is entered.
  - `iter_o`/`phase_o` read 1/0 at S3, 2/1 at S8 and 11/2 at S45.
- Stall: assert `hold_i` for 3 cycles while in S20.
  - S20 is held for 4 cycles in total, then S21 follows.
  - Total run is 49 cycles.
- Special operand: `special_i`=1 during S1.
  - The state sequence is 1, 46, 0.
  - `done_o` is high for one cycle.
- Start while busy and reset mid-operation:
  - `start_i` pulses in S10 and in S46 cause no restart; S0 follows S46.
  - `rst_ni`=0 in S30 gives S0 on the next edge, with all outputs 0.
- With `SQRT_EARLY_EXIT_EN` defined: `conv_i`=1 in S14 gives S14 → S46 → S0.
  - The same `conv_i`=1 applied in S13 has no effect.
  - Without the macro, the run completes all 46 states.
